// File: rtl/audio_sdm_pkg.sv
// Shared types and helpers for the multi-channel sigma-delta audio DAC.
package audio_sdm_pkg;

    localparam int unsigned MAX_WIDTH = 24;
    localparam int unsigned INT_MAX_W = MAX_WIDTH + 3;

    // Unity gain code for a given gain resolution.
    function automatic int unsigned unity(input int unsigned gain_bits);
        return 32'd1 << gain_bits;
    endfunction

    // Offset-binary samples become two's complement by flipping the sample MSB.
    function automatic logic [MAX_WIDTH-1:0] to_signed(input logic [MAX_WIDTH-1:0] sample,
                                                       input int unsigned width,
                                                       input bit signed_in);
        logic [MAX_WIDTH-1:0] r;
        r = sample;
        if (!signed_in) begin
            r[width-1] = ~r[width-1];
        end
        return r;
    endfunction

    typedef struct packed {
        logic signed [INT_MAX_W-1:0] i1;
        logic signed [INT_MAX_W-1:0] i2;
    } sdm_state_t;

endpackage

// File: rtl/sdm_channel.sv
// One DAC channel: registered gain scaling followed by the PDM modulator.
// SDM_DAC_SECOND_ORDER_EN selects a saturating second-order loop instead of first order.
module sdm_channel
    import audio_sdm_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned GAIN_BITS = 6
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     sample,
    input  logic [GAIN_BITS:0]   gain,
    output logic                 dac_out
);

    localparam int unsigned PW = WIDTH + GAIN_BITS + 2;

    logic signed [PW-1:0]    product;
    logic signed [WIDTH-1:0] scaled_q;
    logic                    unused_product;

    assign product        = PW'($signed(sample)) * $signed(PW'(gain));
    assign unused_product = ^product;

    // Slicing above GAIN_BITS is an arithmetic shift; the result always fits WIDTH.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            scaled_q <= '0;
        end else begin
            scaled_q <= product[GAIN_BITS +: WIDTH];
        end
    end

`ifdef SDM_DAC_SECOND_ORDER_EN
    localparam int unsigned IW = WIDTH + 3;
    localparam int unsigned SW = WIDTH + 5;
    localparam logic signed [SW-1:0] FB_POS = SW'(2 ** (WIDTH - 1));
    localparam logic signed [SW-1:0] FB_NEG = -FB_POS;
    localparam logic signed [SW-1:0] SAT_HI = SW'(2 ** (WIDTH + 2) - 1);
    localparam logic signed [SW-1:0] SAT_LO = -SAT_HI;

    sdm_state_t           state_q;
    logic signed [IW-1:0] i1, i2, i1_d, i2_d;
    logic signed [SW-1:0] fb, i1_sum, i2_sum;
    logic                 unused_state;

    function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] v);
        if (v > SAT_HI) return SAT_HI[IW-1:0];
        if (v < SAT_LO) return SAT_LO[IW-1:0];
        return v[IW-1:0];
    endfunction

    assign i1           = state_q.i1[IW-1:0];
    assign i2           = state_q.i2[IW-1:0];
    assign unused_state = ^state_q;

    always_comb begin
        fb     = dac_out ? FB_POS : FB_NEG;
        i1_sum = SW'(i1) + SW'(scaled_q) - fb;
        i2_sum = SW'(i2) + SW'(i1) - fb;
        i1_d   = sat(i1_sum);
        i2_d   = sat(i2_sum);
    end

    // Deciding on the next i2 keeps the input-to-output latency equal to first order.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= '0;
            dac_out <= 1'b0;
        end else begin
            state_q.i1 <= INT_MAX_W'(i1_d);
            state_q.i2 <= INT_MAX_W'(i2_d);
            dac_out    <= ~i2_d[IW-1];
        end
    end
`else
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH - 1){1'b0}}};

    logic [WIDTH:0] acc_q;

    // The carry out of the offset-binary accumulator is the PDM bit.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= '0;
            dac_out <= 1'b0;
        end else begin
            acc_q   <= {1'b0, acc_q[WIDTH-1:0]} + {1'b0, scaled_q ^ MSB_MASK};
            dac_out <= acc_q[WIDTH];
        end
    end
`endif

endmodule

// File: rtl/audio_sdm_dac.sv
// Multi-channel sigma-delta audio DAC: input latch, soft-mute gain ramp, per-channel modulators.
// Define SDM_DAC_SECOND_ORDER_EN to build second-order modulators.
module audio_sdm_dac
    import audio_sdm_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned SIGNED_IN = 1,
    parameter int unsigned GAIN_BITS = 6,
    parameter int unsigned RAMP_DIV  = 256
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      mute,
    output logic [CHANNELS-1:0]       dac_out,
    output logic                      muted
);

    localparam int unsigned UNITY = unity(GAIN_BITS);
    localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(RAMP_DIV - 1);
    localparam logic [GAIN_BITS:0] GAIN_MAX = (GAIN_BITS + 1)'(UNITY);

    logic [CHANNELS*WIDTH-1:0] sample_d, sample_q;
    logic [DIV_W-1:0]          div_q;
    logic [GAIN_BITS:0]        gain_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_conv
        logic [MAX_WIDTH-1:0] conv;
        logic                 unused_conv;
        assign conv = to_signed(MAX_WIDTH'(in_data[c*WIDTH +: WIDTH]), WIDTH, SIGNED_IN != 0);
        assign sample_d[c*WIDTH +: WIDTH] = conv[WIDTH-1:0];
        assign unused_conv = ^conv;
    end

    // Zero-order hold: samples only change on in_valid.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sample_q <= '0;
        end else if (in_valid) begin
            sample_q <= sample_d;
        end
    end

    // Gain steps once per divider wrap; reversing mute just changes the step direction.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            div_q  <= '0;
            gain_q <= '0;
            muted  <= 1'b0;
        end else begin
            muted <= mute && (gain_q == '0);
            if (div_q == DIV_LAST) begin
                div_q <= '0;
                if (mute) begin
                    if (gain_q != '0) gain_q <= gain_q - 1'b1;
                end else if (gain_q != GAIN_MAX) begin
                    gain_q <= gain_q + 1'b1;
                end
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        sdm_channel #(
            .WIDTH    (WIDTH),
            .GAIN_BITS(GAIN_BITS)
        ) u_ch (
            .clk_sys(clk_sys),
            .reset_n(reset_n),
            .sample (sample_q[c*WIDTH +: WIDTH]),
            .gain   (gain_q),
            .dac_out(dac_out[c])
        );
    end

endmodule

// File: doc/audio_sdm_dac.md
Name: audio_sdm_dac

Overview:
- Parametrised multi-channel sigma-delta audio DAC; successor to the fixed 6-bit single-channel dac.
- Sits between emsx_top audio outputs (pDac_SL/pDac_SR and wider mixes) and the AUDIO_L/AUDIO_R pins; one 1-bit PDM output per channel.
- Adds input sample latching, signed/unsigned input, click-free soft mute via a gain ramp, and a selectable modulator order.

Parameters:
- WIDTH, 16, sample width per channel (min 4, max 24).
- CHANNELS, 2, number of independent channels (1..8).
- SIGNED_IN, 1, 1 = two's-complement input; 0 = offset-binary input.
- GAIN_BITS, 6, gain resolution; unity gain = 2^GAIN_BITS.
- RAMP_DIV, 256, clk_sys cycles per gain step (>=1).

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  qualifies in_data; 1-cycle strobe or held high.
- in_data  in  CHANNELS*WIDTH  channel c at bits [c*WIDTH +: WIDTH].
- mute  in  1  level; 1 = ramp gain to 0, 0 = ramp to unity.
- dac_out  out  CHANNELS  registered PDM bitstream per channel.
- muted  out  1  1 when gain==0 and mute==1.

Behaviour:
- Reset values: dac_out=0, muted=0, sample regs=0 (signed zero), gain=0, ramp divider=0, integrators=0. Ramp-up starts after reset unless mute=1.
- Input stage: on in_valid=1, latch all channels (cycle n -> sample reg at n+1). When in_valid=0, hold the last sample (zero-order hold).
- If SIGNED_IN=0, convert to signed by inverting the MSB at the latch.
- Gain stage, registered, n+2: scaled = (sample * gain) >>> GAIN_BITS.
  - Signed arithmetic with truncation toward -inf.
  - gain range is 0..2^GAIN_BITS, so the result fits WIDTH bits with no saturation.
  - Muting ramps toward midscale, never toward rail.
- Ramp: a divider counts 0..RAMP_DIV-1. On wrap, gain moves one step toward its target (0 if mute, 2^GAIN_BITS otherwise), saturating at the target. A mute toggle mid-ramp reverses direction from the current gain without jumping. A full ramp takes 2^GAIN_BITS*RAMP_DIV cycles.
- Modulator, first order (default):
  - acc is WIDTH+1 unsigned: acc <= {1'b0,acc[WIDTH-1:0]} + (scaled ^ MSB-mask), using offset-binary.
  - dac_out <= acc[WIDTH].
  - Midscale gives a 50% duty cycle. Full-scale positive gives ones except 1 in 2^WIDTH; full-scale negative gives all zeros.
- Latency from in_valid to first affected dac_out edge: 4 cycles.
- muted is registered and updates the cycle after gain reaches 0 with mute=1. It clears the cycle after mute deasserts.
- Reset asserted mid-operation clears everything asynchronously. On release, output restarts at 0 with gain=0.

Optional Feature:
- Macro SDM_DAC_SECOND_ORDER_EN.
- Defined: second-order modulator per channel.
  - Integrators i1, i2 are signed WIDTH+3 bits. fb = dac_out ? +2^(WIDTH-1) : -2^(WIDTH-1).
  - i1 <= i1 + scaled - fb; i2 <= i2 + i1 - fb; dac_out <= (i2 >= 0).
  - Both integrators saturate at ±(2^(WIDTH+2)-1); no wrap.
  - Latency unchanged.
- Undefined: first-order modulator as above, and no integrator saturation logic.

Decomposition:
- Package audio_sdm_pkg:
  - function to_signed(sample, signed_in).
  - localparam UNITY = 2^GAIN_BITS as a function of GAIN_BITS.
  - typedef for the per-channel integrator state struct.
- Sub-module sdm_channel: gain multiply plus modulator for one channel, generated CHANNELS times.
- Top level holds the input latch, shared ramp divider, gain counter and muted flag.

Test Plan:
- WIDTH=6, SIGNED_IN=0, mute=0, after ramp completes, in_data=32 held -> dac_out duty exactly 32/64 over 64 cycles; in_data=63 -> 63 ones per 64 cycles.
- SIGNED_IN=1, WIDTH=16, CHANNELS=2, ch0=+16384, ch1=-16384, unity gain -> ch0 duty 75%±1/65536, ch1 25%, measured over 65536 cycles.
- GAIN_BITS=2, RAMP_DIV=4, mute pulse at gain=4 -> gain 3,2,1,0 at 4-cycle intervals, muted=1 one cycle after gain=0, dac_out duty 50%; mute released -> gain climbs back to 4 in 16 cycles.
- in_valid=1 for one cycle with new value -> dac_out duty changes starting exactly 4 cycles later; value holds while in_valid=0.
- reset_n low mid-ramp with a non-zero sample -> dac_out=0, muted=0 immediately (asynchronous); after release, gain restarts from 0.
- SDM_DAC_SECOND_ORDER_EN defined, full-scale +32767 held 10^5 cycles -> i1/i2 never exceed the saturation bound, duty ≥ 99.99%, no wrap glitch.
